// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
// The state enum, mux select codes and condition codes live here so the FSM and decode agree.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } mc_state_t;

    localparam logic [1:0] SRCA_A      = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    localparam logic [1:0] SRCB_WD     = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    typedef struct packed {
        logic       nextpc;
        logic       irwrite;
        logic       adrsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       regw;
        logic       memw;
        logic       branch;
        logic       aluop;
    } ctrl_t;

    // Ungated control word for each state; anything not set stays 0.
    function automatic ctrl_t state_ctrl(mc_state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.irwrite   = 1'b1;
                c.nextpc    = 1'b1;
                c.alusrca   = SRCA_PC;
                c.alusrcb   = SRCB_FOUR;
                c.resultsrc = RES_ALURESULT;
            end
            DECODE: begin
                c.alusrca   = SRCA_PC;
                c.alusrcb   = SRCB_FOUR;
                c.resultsrc = RES_ALURESULT;
            end
            MEMADR: begin
                c.alusrca = SRCA_A;
                c.alusrcb = SRCB_IMM;
            end
            MEMREAD: begin
                c.adrsrc    = 1'b1;
                c.resultsrc = RES_ALUOUT;
            end
            MEMWB: begin
                c.resultsrc = RES_DATA;
                c.regw      = 1'b1;
            end
            MEMWRITE: begin
                c.adrsrc    = 1'b1;
                c.resultsrc = RES_ALUOUT;
                c.memw      = 1'b1;
            end
            EXECUTER: begin
                c.alusrcb = SRCB_WD;
                c.aluop   = 1'b1;
            end
            EXECUTEI: begin
                c.alusrcb = SRCB_IMM;
                c.aluop   = 1'b1;
            end
            ALUWB: begin
                c.resultsrc = RES_ALUOUT;
                c.regw      = 1'b1;
            end
            BRANCH: begin
                c.alusrca   = SRCA_ALUOUT;
                c.alusrcb   = SRCB_IMM;
                c.resultsrc = RES_ALURESULT;
                c.branch    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_mainfsm.sv
// Main sequencing FSM: state register, next-state logic and the per-state control word.
// Controls are registered from the next state, so they are a pure function of the current state.
module mc_mainfsm
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic       funct5,
    input  logic       funct0,
    output logic [3:0] state,
    output logic       nextpc,
    output logic       irwrite,
    output logic       adrsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic       regw,
    output logic       memw,
    output logic       branch,
    output logic       aluop
);

    mc_state_t state_q;
    mc_state_t state_d;
    ctrl_t     ctrl_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (op)
                    2'b01:   state_d = MEMADR;
                    2'b00:   state_d = funct5 ? EXECUTEI : EXECUTER;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = funct0 ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = MEMWB;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            default:  state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            ctrl_q  <= state_ctrl(FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d);
        end
    end

    assign state     = state_q;
    assign nextpc    = ctrl_q.nextpc;
    assign irwrite   = ctrl_q.irwrite;
    assign adrsrc    = ctrl_q.adrsrc;
    assign alusrca   = ctrl_q.alusrca;
    assign alusrcb   = ctrl_q.alusrcb;
    assign resultsrc = ctrl_q.resultsrc;
    assign regw      = ctrl_q.regw;
    assign memw      = ctrl_q.memw;
    assign branch    = ctrl_q.branch;
    assign aluop     = ctrl_q.aluop;

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM controller: instruction decode, condition check, Flags and CondEx registers.
// Writes are gated by the condition latched at the end of DECODE, never by live ALU flags.
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl,
    output logic [3:0]  state,
    output logic [3:0]  flags,
    output logic        condex_reg
);

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       unused_instr;

    assign cond  = Instr[31:28];
    assign op    = Instr[27:26];
    assign funct = Instr[25:20];
    assign rd    = Instr[15:12];
    assign unused_instr = ^{Instr[19:16], Instr[11:0]};

    logic       nextpc, regw, memw, branch, aluop;
    logic [1:0] flagw;
    logic       condex;
    logic       condex_q;
    logic [3:0] flags_q;
    logic       pcs;

    mc_mainfsm u_fsm (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct5    (funct[5]),
        .funct0    (funct[0]),
        .state     (state),
        .nextpc    (nextpc),
        .irwrite   (IRWrite),
        .adrsrc    (AdrSrc),
        .alusrca   (ALUSrcA),
        .alusrcb   (ALUSrcB),
        .resultsrc (ResultSrc),
        .regw      (regw),
        .memw      (memw),
        .branch    (branch),
        .aluop     (aluop)
    );

    assign ImmSrc = op;
    assign RegSrc = {(op == 2'b01) & ~funct[0], (op == 2'b10)};

    // Unknown data-processing codes fall back to ADD and leave the flags alone.
    always_comb begin
        ALUControl = ALU_ADD;
        flagw      = 2'b00;
        if (aluop) begin
            case (funct[4:1])
                4'b0100: begin ALUControl = ALU_ADD; flagw = {2{funct[0]}}; end
                4'b0010: begin ALUControl = ALU_SUB; flagw = {2{funct[0]}}; end
                4'b0000: begin ALUControl = ALU_AND; flagw = {funct[0], 1'b0}; end
                4'b1100: begin ALUControl = ALU_ORR; flagw = {funct[0], 1'b0}; end
                default: begin ALUControl = ALU_ADD; flagw = 2'b00; end
            endcase
        end
    end

    logic n, z, c, v;
    assign {n, z, c, v} = flags_q;

    always_comb begin
        condex = 1'b0;
        case (cond)
            COND_EQ: condex = z;
            COND_NE: condex = ~z;
            COND_CS: condex = c;
            COND_CC: condex = ~c;
            COND_MI: condex = n;
            COND_PL: condex = ~n;
            COND_VS: condex = v;
            COND_VC: condex = ~v;
            COND_HI: condex = c & ~z;
            COND_LS: condex = ~c | z;
            COND_GE: condex = (n == v);
            COND_LT: condex = (n != v);
            COND_GT: condex = ~z & (n == v);
            COND_LE: condex = z | (n != v);
            COND_AL: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    // aluop is only high in the execute states, so its edge is the one that ends them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            if (state == DECODE)
                condex_q <= condex;
            if (aluop && condex_q && flagw[1])
                flags_q[3:2] <= ALUFlags[3:2];
            if (aluop && condex_q && flagw[0])
                flags_q[1:0] <= ALUFlags[1:0];
        end
    end

    assign pcs      = ((rd == 4'hF) & regw) | branch;
    assign PCWrite  = (pcs & condex_q) | nextpc;
    assign RegWrite = regw & condex_q;
    assign MemWrite = memw & condex_q;

    assign flags      = flags_q;
    assign condex_reg = condex_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed instruction scenarios plus random
// instructions checked cycle by cycle against an instruction-level reference model.
module tb_mc_controller;
    import mc_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
    logic [3:0]  state;
    logic [3:0]  flags;
    logic        condex_reg;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .state      (state),
        .flags      (flags),
        .condex_reg (condex_reg)
    );

    always #5 clk = ~clk;

    // Bit layout: PCWrite MemWrite RegWrite IRWrite AdrSrc RegSrc ALUSrcA ALUSrcB ResultSrc ImmSrc ALUControl
    logic [16:0] obs;
    assign obs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
                  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};
    localparam int B_PCW = 16, B_MW = 15, B_RW = 14, B_ADR = 12;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]  m_flags;
    logic        m_condex;
    mc_state_t   seq_q[$];
    logic [3:0]  seen_state[8];
    logic [16:0] seen_obs[8];

    function automatic logic cond_holds(input logic [3:0] cnd, input logic [3:0] f);
        logic fn, fz, fc, fv;
        {fn, fz, fc, fv} = f;
        case (cnd)
            4'd0:  return fz;
            4'd1:  return !fz;
            4'd2:  return fc;
            4'd3:  return !fc;
            4'd4:  return fn;
            4'd5:  return !fn;
            4'd6:  return fv;
            4'd7:  return !fv;
            4'd8:  return fc && !fz;
            4'd9:  return !fc || fz;
            4'd10: return fn == fv;
            4'd11: return fn != fv;
            4'd12: return !fz && (fn == fv);
            4'd13: return fz || (fn != fv);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Expected state walk of one instruction, derived from its class.
    task automatic build_seq(input logic [31:0] ins);
        logic [1:0] op;
        op = ins[27:26];
        seq_q = {};
        seq_q.push_back(FETCH);
        seq_q.push_back(DECODE);
        if (op == 2'b01) begin
            seq_q.push_back(MEMADR);
            if (ins[20]) begin
                seq_q.push_back(MEMREAD);
                seq_q.push_back(MEMWB);
            end else begin
                seq_q.push_back(MEMWRITE);
            end
        end else if (op == 2'b00) begin
            seq_q.push_back(ins[25] ? EXECUTEI : EXECUTER);
            seq_q.push_back(ALUWB);
        end else if (op == 2'b10) begin
            seq_q.push_back(BRANCH);
        end
    endtask

    // Runs one instruction from FETCH, checking every cycle; caller sits just after a rising edge in FETCH.
    task automatic run_instr(input logic [31:0] ins, input logic [3:0] af);
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [3:0]  cmd;
        logic        is_dp_known, addsub;
        logic        irw, nextpc, adr, regw, memw, br, aluop;
        logic [1:0]  sa, sb, rs, aluc, rsrc;
        logic [16:0] exp_obs;
        mc_state_t   s;
        op  = ins[27:26];
        fn  = ins[25:20];
        cmd = fn[4:1];
        Instr    = ins;
        ALUFlags = af;
        build_seq(ins);
        for (int i = 0; i < seq_q.size(); i++) begin
            #1;
            s      = seq_q[i];
            irw    = (s == FETCH);
            nextpc = (s == FETCH);
            adr    = (s == MEMREAD) || (s == MEMWRITE);
            sa     = (s == FETCH || s == DECODE) ? 2'b01 : (s == BRANCH) ? 2'b10 : 2'b00;
            sb     = (s == FETCH || s == DECODE) ? 2'b10 :
                     (s == MEMADR || s == EXECUTEI || s == BRANCH) ? 2'b01 : 2'b00;
            rs     = (s == FETCH || s == DECODE || s == BRANCH) ? 2'b10 : (s == MEMWB) ? 2'b01 : 2'b00;
            regw   = (s == MEMWB) || (s == ALUWB);
            memw   = (s == MEMWRITE);
            br     = (s == BRANCH);
            aluop  = (s == EXECUTER) || (s == EXECUTEI);
            aluc   = 2'b00;
            if (aluop) begin
                if (cmd == 4'b0010) aluc = 2'b01;
                else if (cmd == 4'b0000) aluc = 2'b10;
                else if (cmd == 4'b1100) aluc = 2'b11;
            end
            rsrc = {(op == 2'b01) && !fn[0], (op == 2'b10)};
            exp_obs = {((((ins[15:12] == 4'hF) && regw) || br) && m_condex) || nextpc,
                       memw && m_condex, regw && m_condex, irw, adr, rsrc,
                       sa, sb, rs, op, aluc};
            n_tests++;
            if (state !== 4'(s)) begin
                n_fail++;
                $display("FAIL state ins=%08h cyc=%0d got=%0d exp=%s", ins, i, state, s.name());
            end
            n_tests++;
            if (obs !== exp_obs) begin
                n_fail++;
                $display("FAIL outputs ins=%08h state=%s got=%05h exp=%05h", ins, s.name(), obs, exp_obs);
            end
            seen_state[i] = state;
            seen_obs[i]   = obs;
            if (s == DECODE)
                m_condex = cond_holds(ins[31:28], m_flags);
            if (aluop && m_condex) begin
                is_dp_known = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b0000) || (cmd == 4'b1100);
                addsub      = (cmd == 4'b0100) || (cmd == 4'b0010);
                if (fn[0] && is_dp_known) m_flags[3:2] = af[3:2];
                if (fn[0] && addsub)      m_flags[1:0] = af[1:0];
            end
            @(posedge clk);
        end
        #1;
        n_tests++;
        if (flags !== m_flags || condex_reg !== m_condex) begin
            n_fail++;
            $display("FAIL flags ins=%08h got=%b/%b exp=%b/%b", ins, flags, condex_reg, m_flags, m_condex);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        Instr = 32'h0;
        ALUFlags = 4'h0;
        #2;
        n_tests++;
        if (state !== 4'(FETCH) || flags !== 4'b0000 || condex_reg !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state got=%0d/%b/%b exp=0/0000/0", state, flags, condex_reg);
        end
        n_tests++;
        if (obs !== 17'b1_0_0_1_0_00_01_10_10_00_00) begin
            n_fail++;
            $display("FAIL reset_outputs got=%05h exp=%05h", obs, 17'b1_0_0_1_0_00_01_10_10_00_00);
        end
        m_flags  = 4'b0000;
        m_condex = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_add();
        run_instr(32'hE0821003, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (seen_obs[i][B_RW] !== (i == 3)) begin
                n_fail++;
                $display("FAIL add_regwrite cyc=%0d got=%b exp=%b", i, seen_obs[i][B_RW], (i == 3));
            end
        end
        n_tests++;
        if (seen_obs[2][1:0] !== 2'b00) begin
            n_fail++;
            $display("FAIL add_alucontrol got=%b exp=00", seen_obs[2][1:0]);
        end
    endtask

    task automatic test_ldr();
        run_instr(32'hE5921004, 4'b0000);
        n_tests++;
        if (seen_obs[3][B_ADR] !== 1'b1) begin
            n_fail++;
            $display("FAIL ldr_adrsrc got=%b exp=1", seen_obs[3][B_ADR]);
        end
        n_tests++;
        if (seen_obs[4][5:4] !== 2'b01 || seen_obs[4][B_RW] !== 1'b1) begin
            n_fail++;
            $display("FAIL ldr_memwb got=%b/%b exp=01/1", seen_obs[4][5:4], seen_obs[4][B_RW]);
        end
    endtask

    task automatic test_str();
        run_instr(32'hE5821004, 4'b0000);
        n_tests++;
        if (seen_obs[3][B_MW] !== 1'b1 || seen_obs[3][11:10] !== 2'b10) begin
            n_fail++;
            $display("FAIL str_memwrite got=%b/%b exp=1/10", seen_obs[3][B_MW], seen_obs[3][11:10]);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (seen_obs[i][B_RW] !== 1'b0) begin
                n_fail++;
                $display("FAIL str_regwrite cyc=%0d got=%b exp=0", i, seen_obs[i][B_RW]);
            end
        end
    endtask

    task automatic test_flags_branch();
        run_instr(32'hE2500001, 4'b0100);
        n_tests++;
        if (flags !== 4'b0100) begin
            n_fail++;
            $display("FAIL subs_flags got=%b exp=0100", flags);
        end
        run_instr(32'h0A000002, 4'b0000);
        n_tests++;
        if (seen_obs[2][B_PCW] !== 1'b1) begin
            n_fail++;
            $display("FAIL beq_taken got=%b exp=1", seen_obs[2][B_PCW]);
        end
        run_instr(32'h1A000002, 4'b0000);
        n_tests++;
        if (seen_obs[2][B_PCW] !== 1'b0) begin
            n_fail++;
            $display("FAIL bne_not_taken got=%b exp=0", seen_obs[2][B_PCW]);
        end
    endtask

    task automatic test_add_pc();
        run_instr(32'hE08FF003, 4'b0000);
        n_tests++;
        if (seen_obs[3][B_PCW] !== 1'b1 || seen_obs[3][B_RW] !== 1'b1) begin
            n_fail++;
            $display("FAIL addpc_aluwb got=%b/%b exp=1/1", seen_obs[3][B_PCW], seen_obs[3][B_RW]);
        end
    endtask

    task automatic test_random();
        logic [3:0]  cmds[5];
        logic [3:0]  cnd, cmd;
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [31:0] ins;
        cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000; cmds[3] = 4'b1100; cmds[4] = 4'b1010;
        for (int k = 0; k < 80; k++) begin
            cnd = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            op  = 2'($urandom_range(0, 3));
            fn  = 6'($urandom_range(0, 63));
            if (op == 2'b00) begin
                cmd = cmds[$urandom_range(0, 4)];
                fn[4:1] = cmd;
                if (cmd == 4'b1010) fn[0] = 1'b0;
            end
            ins = {cnd, op, fn, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   12'($urandom_range(0, 4095))};
            run_instr(ins, 4'($urandom_range(0, 15)));
        end
    endtask

    task automatic test_reset_midread();
        run_instr(32'hE2500001, 4'b1010);
        n_tests++;
        if (flags !== 4'b1010) begin
            n_fail++;
            $display("FAIL pre_reset_flags got=%b exp=1010", flags);
        end
        Instr = 32'hE5921004;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (state !== 4'(MEMREAD)) begin
            n_fail++;
            $display("FAIL reach_memread got=%0d exp=%0d", state, 4'(MEMREAD));
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (state !== 4'(FETCH) || flags !== 4'b0000 || condex_reg !== 1'b0) begin
            n_fail++;
            $display("FAIL midread_reset got=%0d/%b/%b exp=0/0000/0", state, flags, condex_reg);
        end
        n_tests++;
        if ({obs[16:12], obs[9:4], obs[1:0]} !== 13'b1_0_0_1_0_01_10_10_00) begin
            n_fail++;
            $display("FAIL midread_outputs got=%05h", obs);
        end
        m_flags  = 4'b0000;
        m_condex = 1'b0;
        Instr = 32'hFC000000;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_tests++;
            if (RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_write cyc=%0d got=%b/%b exp=0/0", i, RegWrite, MemWrite);
            end
            @(posedge clk);
        end
        #1;
        run_instr(32'hE0821003, 4'b0000);
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldr();
        test_str();
        test_flags_branch();
        test_add_pc();
        test_random();
        test_reset_midread();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port Instr, input, 32 bits: the instruction register contents; only [31:12] are used (Cond=[31:28], Op=[27:26], Funct=[25:20], Rd=[15:12]).
REQ-004 The block SHALL have port ALUFlags, input, 4 bits: {N,Z,C,V} from the datapath ALU.
REQ-005 The block SHALL have the following 1-bit outputs: PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc.
REQ-006 The block SHALL have the following 2-bit outputs: RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl.

Function
REQ-007 Encodings SHALL be as follows.
- ALUSrcA: 00=A, 01=PC, 10=ALUOut.
- ALUSrcB: 00=WriteData, 01=ExtImm, 10=constant 4.
- ResultSrc: 00=ALUOut, 01=Data, 10=ALUResult.
- AdrSrc: 0=PC, 1=Result.
REQ-008 The main FSM SHALL have the states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB and BRANCH.
REQ-009 State transitions SHALL be as follows.
- FETCH->DECODE.
- DECODE: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECUTER; Op=00 with Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> FETCH (NOP).
- MEMADR: Funct[0]=1 -> MEMREAD; Funct[0]=0 -> MEMWRITE.
- MEMREAD->MEMWB.
- EXECUTER and EXECUTEI -> ALUWB.
- MEMWB, MEMWRITE, ALUWB and BRANCH -> FETCH.
REQ-010 Per-state controls SHALL be as listed; any signal not listed is 0.
- FETCH: IRWrite=1, NextPC=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcA=00, ALUSrcB=01.
- MEMREAD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1.
- EXECUTER: ALUSrcB=00, ALUOp=1.
- EXECUTEI: ALUSrcB=01, ALUOp=1.
- ALUWB: ResultSrc=00, RegW=1.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1.
REQ-011 Every output SHALL be a combinational function of the state, Instr and the registered condition state; an output SHALL NOT depend combinationally on ALUFlags.
REQ-012 Decode SHALL be as follows.
- ImmSrc=Op.
- RegSrc[0]=1 iff Op=10.
- RegSrc[1]=1 iff Op=01 and Funct[0]=0.
REQ-013 When ALUOp=1, ALUControl SHALL be derived from Funct[4:1] as follows.
- 0100 (ADD) -> 00.
- 0010 (SUB) -> 01.
- 0000 (AND) -> 10.
- 1100 (ORR) -> 11.
- Any other code -> 00, with no flag write.
REQ-014 When ALUOp=0, ALUControl SHALL be 00.
REQ-015 FlagW[1] (updates N,Z) SHALL equal ALUOp&Funct[0].
REQ-016 FlagW[0] (updates C,V) SHALL equal ALUOp&Funct[0]&(ADD|SUB).
REQ-017 CondEx SHALL be evaluated from Cond and the current Flags register for all 15 ARM codes (EQ..LE, AL=1110).
REQ-018 Cond=1111 SHALL evaluate to CondEx=0.
REQ-019 CondEx SHALL be captured into CondExReg at the clock edge that ends DECODE.
REQ-020 All execution gating SHALL use CondExReg.
REQ-021 The Flags register SHALL update Flags[3:2] from ALUFlags[3:2] at the clock edge ending EXECUTER/EXECUTEI iff FlagW[1]&CondExReg.
REQ-022 The Flags register SHALL update Flags[1:0] from ALUFlags[1:0] at the clock edge ending EXECUTER/EXECUTEI iff FlagW[0]&CondExReg.
REQ-023 PCS SHALL equal (Rd=1111 & RegW) | Branch.
REQ-024 Gated outputs SHALL be as follows.
- PCWrite = (PCS & CondExReg) | NextPC.
- RegWrite = RegW & CondExReg.
- MemWrite = MemW & CondExReg.
REQ-025 A failed condition SHALL still traverse the full state sequence, with all writes suppressed.
REQ-026 Each instruction SHALL take the following number of cycles.
- LDR: 5.
- STR: 4.
- Data-processing: 4.
- Branch: 3.
- Op=11: 2.

Reset
REQ-027 Reset SHALL asynchronously force the state to FETCH, Flags to 0000 and CondExReg to 0.
REQ-028 While reset is high, outputs SHALL equal the FETCH values with CondExReg=0: IRWrite=1, PCWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, all others 0.
REQ-029 Reset asserted in any state SHALL abandon the instruction in progress; no pending RegWrite or MemWrite SHALL occur afterward.

Structure
REQ-030 The shared package mc_ctrl_pkg SHALL contain the FSM state enum, the ALUSrcA/ALUSrcB/ResultSrc/ALUControl encodings and the Cond code constants.
REQ-031 The block SHALL contain one sub-module, mc_mainfsm, holding the state register, next-state logic and per-state controls.
REQ-032 Decode, condition check and the Flags/CondExReg registers SHALL reside in mc_controller.

Verification
REQ-033 The bench SHALL cover ADD R1,R2,R3 (0xE0821003): the state sequence SHALL be FETCH,DECODE,EXECUTER,ALUWB; RegWrite=1 only in ALUWB; ALUControl=00.
REQ-034 The bench SHALL cover LDR R1,[R2,#4] (0xE5921004): the state sequence SHALL be FETCH,DECODE,MEMADR,MEMREAD,MEMWB; AdrSrc=1 in MEMREAD; ResultSrc=01 and RegWrite=1 in MEMWB.
REQ-035 The bench SHALL cover STR R1,[R2,#4] (0xE5821004): MEMWRITE SHALL show MemWrite=1 and RegSrc=10; RegWrite SHALL be 0 throughout.
REQ-036 The bench SHALL cover SUBS R0,R0,#1 (0xE2500001) with ALUFlags=0100 in EXECUTEI, giving Flags=0100; then BEQ (0x0A000002) SHALL give PCWrite=1 in BRANCH, and BNE (0x1A000002) SHALL give PCWrite=0 in BRANCH.
REQ-037 The bench SHALL cover ADD PC,PC,R3 (0xE08FF003): PCWrite=1 and RegWrite=1 in ALUWB.
REQ-038 The bench SHALL cover reset pulsed mid-MEMREAD: the state SHALL immediately be FETCH, Flags=0000, and no MemWrite or RegWrite SHALL occur afterward.
